// File: rtl/jtag_rx_scfifo.sv
// Single-clock receive FIFO for the JTAG UART path: registered pop data,
// exact occupancy counter, full/empty/almost-full decodes and sticky error flags.
module jtag_rx_scfifo #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 64,
   parameter int AFULL_LVL = 56,
   parameter int USED_W    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              fifo_rd,
   input  logic              flush,
   input  logic              clr_err,
   output logic [DATA_W-1:0] fifo_rdata,
   output logic              fifo_EF,
   output logic              rfifo_full,
   output logic              rfifo_afull,
   output logic [USED_W-1:0] rfifo_used,
   output logic              overflow,
   output logic              underflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [USED_W-1:0] used_r;
   logic [DATA_W-1:0] rdata_r;
   logic              overflow_r;
   logic              underflow_r;

   logic              empty_s;
   logic              full_s;
   logic              push_s;
   logic              pop_s;
   logic              push_rej_s;
   logic              pop_rej_s;

   assign empty_s = (used_r == {USED_W{1'b0}});
   assign full_s  = (used_r == USED_W'(DEPTH));

   // Accept/reject decisions; flush suppresses both the requests and their errors.
   always_comb begin
      push_s     = 1'b0;
      pop_s      = 1'b0;
      push_rej_s = 1'b0;
      pop_rej_s  = 1'b0;
      if (flush) begin
         push_s     = 1'b0;
         pop_s      = 1'b0;
         push_rej_s = 1'b0;
         pop_rej_s  = 1'b0;
      end else begin
         push_s     = wr_en && (!full_s || fifo_rd);
         pop_s      = fifo_rd && !empty_s;
         push_rej_s = wr_en && !push_s;
         pop_rej_s  = fifo_rd && !pop_s;
      end
   end

   // Storage array; contents are don't-care after reset so it carries none.
   always_ff @(posedge clk) begin
      if (rst_n && push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers, occupancy, read data register and sticky error flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         used_r      <= {USED_W{1'b0}};
         rdata_r     <= {DATA_W{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            used_r   <= {USED_W{1'b0}};
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
               // Read happens before a same-cycle write lands, so at full the oldest word leaves.
               rd_ptr_r <= rd_ptr_r + PTR_W'(1);
               rdata_r  <= mem_r[rd_ptr_r];
            end
            case ({push_s, pop_s})
               2'b10:   used_r <= used_r + USED_W'(1);
               2'b01:   used_r <= used_r - USED_W'(1);
               default: used_r <= used_r;
            endcase
         end
         overflow_r  <= (overflow_r  && !clr_err) || push_rej_s;
         underflow_r <= (underflow_r && !clr_err) || pop_rej_s;
      end
   end

   assign fifo_rdata  = rdata_r;
   assign fifo_EF     = empty_s;
   assign rfifo_full  = full_s;
   assign rfifo_afull = (used_r >= USED_W'(AFULL_LVL));
   assign rfifo_used  = used_r;
   assign overflow    = overflow_r;
   assign underflow   = underflow_r;

endmodule

// File: tb/tb_jtag_rx_scfifo.sv
// Self-checking bench for jtag_rx_scfifo: queue scoreboard against a default
// (8x64) instance and a 16x8 instance, checking every output after every edge.
module tb_jtag_rx_scfifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: DATA_W=8, DEPTH=64, AFULL_LVL=56
   logic        a_rst_n, a_wr_en, a_rd, a_flush, a_clr;
   logic [7:0]  a_wr_data, a_rdata;
   logic        a_ef, a_full, a_afull, a_ovf, a_udf;
   logic [6:0]  a_used;

   // Instance B: DATA_W=16, DEPTH=8, AFULL_LVL=6
   logic        b_rst_n, b_wr_en, b_rd, b_flush, b_clr;
   logic [15:0] b_wr_data, b_rdata;
   logic        b_ef, b_full, b_afull, b_ovf, b_udf;
   logic [3:0]  b_used;

   jtag_rx_scfifo dut_a (
      .clk(clk), .rst_n(a_rst_n), .wr_en(a_wr_en), .wr_data(a_wr_data),
      .fifo_rd(a_rd), .flush(a_flush), .clr_err(a_clr),
      .fifo_rdata(a_rdata), .fifo_EF(a_ef), .rfifo_full(a_full),
      .rfifo_afull(a_afull), .rfifo_used(a_used),
      .overflow(a_ovf), .underflow(a_udf)
   );

   jtag_rx_scfifo #(.DATA_W(16), .DEPTH(8), .AFULL_LVL(6)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .wr_en(b_wr_en), .wr_data(b_wr_data),
      .fifo_rd(b_rd), .flush(b_flush), .clr_err(b_clr),
      .fifo_rdata(b_rdata), .fifo_EF(b_ef), .rfifo_full(b_full),
      .rfifo_afull(b_afull), .rfifo_used(b_used),
      .overflow(b_ovf), .underflow(b_udf)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboard / reference state for the instance currently under test
   int          sel     = 0;
   int          m_depth = 64;
   int          m_afull = 56;
   logic [15:0] q[$];
   logic [15:0] m_rdata = 16'h0000;
   logic        m_ovf   = 1'b0;
   logic        m_udf   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s (dut %0d, t=%0t): got 0x%0h expected 0x%0h", tag, sel, $time, obs, exp);
      end
   endtask

   // One clock of stimulus to the selected instance, reference update, then full output check.
   task automatic step(input logic we, input logic [15:0] wd, input logic rd,
                       input logic fl, input logic ce, input logic rs);
      logic        push_ok, pop_ok;
      logic [15:0] d;
      logic [31:0] o_used, o_rdata;
      logic        o_ef, o_full, o_afull, o_ovf, o_udf;
      d = (sel == 0) ? (wd & 16'h00FF) : wd;
      a_rst_n = 1'b1; a_wr_en = 1'b0; a_wr_data = 8'h00; a_rd = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
      b_rst_n = 1'b1; b_wr_en = 1'b0; b_wr_data = 16'h0000; b_rd = 1'b0; b_flush = 1'b0; b_clr = 1'b0;
      if (sel == 0) begin
         a_rst_n = rs; a_wr_en = we; a_wr_data = d[7:0]; a_rd = rd; a_flush = fl; a_clr = ce;
      end else begin
         b_rst_n = rs; b_wr_en = we; b_wr_data = d; b_rd = rd; b_flush = fl; b_clr = ce;
      end
      @(posedge clk);
      #1;
      if (!rs) begin
         q.delete();
         m_rdata = 16'h0000;
         m_ovf   = 1'b0;
         m_udf   = 1'b0;
      end else if (fl) begin
         q.delete();
         if (ce) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
         end
      end else begin
         push_ok = we && ((q.size() != m_depth) || rd);
         pop_ok  = rd && (q.size() != 0);
         if (pop_ok) m_rdata = q.pop_front();
         if (push_ok) q.push_back(d);
         m_ovf = (m_ovf && !ce) || (we && !push_ok);
         m_udf = (m_udf && !ce) || (rd && !pop_ok);
      end
      if (sel == 0) begin
         o_used = 32'(a_used); o_rdata = 32'(a_rdata); o_ef = a_ef; o_full = a_full;
         o_afull = a_afull; o_ovf = a_ovf; o_udf = a_udf;
      end else begin
         o_used = 32'(b_used); o_rdata = 32'(b_rdata); o_ef = b_ef; o_full = b_full;
         o_afull = b_afull; o_ovf = b_ovf; o_udf = b_udf;
      end
      check("used",      o_used,  32'(q.size()));
      check("empty",     32'(o_ef),    32'(q.size() == 0));
      check("full",      32'(o_full),  32'(q.size() == m_depth));
      check("afull",     32'(o_afull), 32'(q.size() >= m_afull));
      check("rdata",     o_rdata, 32'(m_rdata));
      check("overflow",  32'(o_ovf),   32'(m_ovf));
      check("underflow", 32'(o_udf),   32'(m_udf));
   endtask

   task automatic push(input logic [15:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic pop();
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic idle();
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      a_rst_n = 1'b0; a_wr_en = 1'b0; a_wr_data = 8'h00; a_rd = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
      b_rst_n = 1'b0; b_wr_en = 1'b0; b_wr_data = 16'h0000; b_rd = 1'b0; b_flush = 1'b0; b_clr = 1'b0;

      // ---------------- instance A: 8 x 64 ----------------
      sel = 0; m_depth = 64; m_afull = 56;
      do_reset();
      idle();
      for (int i = 0; i < 10; i++) push(16'(i + 8'h30));
      // reset mid-stream overrides every other request
      step(1'b1, 16'h00EE, 1'b1, 1'b1, 1'b1, 1'b0);
      idle();

      for (int i = 0; i < 64; i++) push(16'(i));
      for (int i = 0; i < 64; i++) pop();

      for (int i = 0; i < 64; i++) push(16'($urandom_range(0, 255)));
      push(16'h00AA);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 16'h00BB, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 64; i++) pop();

      // streaming through with concurrent pop: 200 words wrap the pointers 3+ times
      push(16'h0000);
      for (int i = 1; i < 200; i++) step(1'b1, 16'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      pop();

      pop();
      step(1'b1, 16'h005A, 1'b1, 1'b0, 1'b0, 1'b1);
      pop();

      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) push(16'(8'hC0 + i));
      step(1'b1, 16'h0077, 1'b1, 1'b1, 1'b0, 1'b1);
      idle();
      pop();
      for (int i = 0; i < 64; i++) push(16'(8'h80 + i));
      step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) pop();

      // ---------------- instance B: 16 x 8 ----------------
      sel = 1; m_depth = 8; m_afull = 6;
      do_reset();
      idle();
      for (int i = 0; i < 10; i++) push(16'(16'h1000 + i));
      step(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0);
      idle();
      for (int i = 0; i < 8; i++) push(16'(16'hA5C3 + 16'h1111 * i));
      push(16'hDEAD);
      step(1'b1, 16'hCAFE, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) pop();
      for (int i = 0; i < 20; i++) step(1'b1, 16'(16'hF00D ^ (i * 16'h0101)), 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) pop();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
